// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a valid/ready request/response handshake
// with a fixed response latency, RV32I byte/half/word access and error checking.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q;
    logic          err_q;
    logic [2:0]    funct3_q;
    logic [1:0]    lane_q;
    logic [AW-1:0] idx_q;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          accept;
    logic          req_misaligned;
    logic          req_out_of_range;
    logic          req_bad_funct3;
    logic          req_err;
    logic [AW-1:0] req_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_val;

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = resp_valid && err_q;
    assign accept     = req_valid && req_ready && rst;
    assign req_idx    = req_addr[AW+1:2];

    always_comb begin
        req_misaligned   = ((req_funct3[1:0] == 2'd1) && req_addr[0])
                        || ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
        req_out_of_range = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
        req_bad_funct3   = req_write ? (req_funct3 > 3'd2)
                                     : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
        req_err          = req_misaligned || req_out_of_range || req_bad_funct3;
    end

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = req_wdata;
        case (req_funct3[1:0])
            2'd0: begin
                wr_be   = 4'b0001 << req_addr[1:0];
                wr_data = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                wr_be   = 4'b0011 << {req_addr[1], 1'b0};
                wr_data = {2{req_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = req_wdata;
            end
        endcase
        if (!(accept && req_write && !req_err)) begin
            wr_be = 4'b0000;
        end
    end

    // NOTE: storage has no reset branch; a reset must leave committed data intact.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                mem_q[req_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(LATENCY - 2);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'd0;
            lane_q   <= 2'd0;
            idx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q  <= req_write;
                err_q    <= req_err;
                funct3_q <= req_funct3;
                lane_q   <= req_addr[1:0];
                idx_q    <= req_idx;
            end
        end
    end

    // Memory cannot change while a response is pending, so reading the
    // captured address combinationally keeps the response stable in RESP.
    always_comb begin
        rd_word = mem_q[idx_q];
        rd_byte = rd_word[{lane_q, 3'b000} +: 8];
        rd_half = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3_q)
            3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
            3'd4:    load_val = {24'd0, rd_byte};
            3'd5:    load_val = {16'd0, rd_half};
            default: load_val = rd_word;
        endcase
        resp_rdata = (resp_valid && !write_q && !err_q) ? load_val : 32'd0;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for data_mem_responder against a byte-array
// reference memory with little-endian load/store rules.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [0:4*DEPTH-1];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed memory, access size 1/2/4, natural alignment.
    task automatic model_apply(input logic w, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] d, output logic [31:0] rd, output logic er);
        longint ua;
        int     size;
        logic [31:0] v;
        bit     illegal;
        ua      = longint'(a);
        size    = 1 << f[1:0];
        illegal = w ? (f > 3'd2) : ((f == 3'd3) || (f >= 3'd6));
        er      = illegal || ((ua % size) != 0) || ((ua / 4) >= DEPTH);
        rd      = 32'd0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < size; i++) model_mem[ua+i] = d[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v = v | (32'(model_mem[ua+i]) << (8*i));
                if (f == 3'd0) v = (v ^ 32'h80) - 32'h80;
                if (f == 3'd1) v = (v ^ 32'h8000) - 32'h8000;
                rd = v;
            end
        end
    endtask

    task automatic do_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input int hold,
                          output logic [31:0] got_rd, output logic got_err);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        model_apply(w, f, a, d, exp_rd, exp_err);
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        check("ready_busy", 32'(req_ready), 32'd0);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        got_rd  = resp_rdata;
        got_err = resp_err;
        if (!resp_valid) begin
            check("resp_timeout", 32'd0, 32'd1);
            return;
        end
        // resp_valid is first sampled high by the edge after it is observed here.
        check("latency", 32'(n + 1), 32'(LAT));
        check("rdata", resp_rdata, exp_rd);
        check("err", 32'(resp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, exp_rd);
            check("hold_err", 32'(resp_err), 32'(exp_err));
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("post_valid", 32'(resp_valid), 32'd0);
        check("post_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        rst = 1'b1;

        for (int wi = 0; wi < 16; wi++) do_req(1'b1, 3'd2, 32'(wi * 4), $urandom, 0, rd, er);

        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er);
        check("sw_err", 32'(er), 32'd0);
        do_req(1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
        check("lw_dir", rd, 32'hDEADBEEF);
        do_req(1'b0, 3'd0, 32'h13, 32'd0, 0, rd, er);
        check("lb_dir", rd, 32'hFFFFFFDE);
        do_req(1'b0, 3'd4, 32'h13, 32'd0, 0, rd, er);
        check("lbu_dir", rd, 32'h000000DE);
        do_req(1'b0, 3'd1, 32'h10, 32'd0, 0, rd, er);
        check("lh_dir", rd, 32'hFFFFBEEF);
        do_req(1'b0, 3'd5, 32'h12, 32'd0, 0, rd, er);
        check("lhu_dir", rd, 32'h0000DEAD);
        do_req(1'b1, 3'd0, 32'h11, 32'h00000055, 0, rd, er);
        do_req(1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
        check("sb_lanes", rd, 32'hDEAD55EF);
        do_req(1'b0, 3'd2, 32'h12, 32'd0, 0, rd, er);
        check("lw_misal_err", 32'(er), 32'd1);
        check("lw_misal_rdata", rd, 32'd0);
        do_req(1'b1, 3'd2, 32'(4 * DEPTH), 32'hFFFFFFFF, 0, rd, er);
        check("sw_range_err", 32'(er), 32'd1);
        do_req(1'b0, 3'd2, 32'h10, 32'd0, 5, rd, er);
        check("lw_after_err", rd, 32'hDEAD55EF);

        // Abort a load in WAIT; a store presented during reset must be ignored.
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_valid", 32'(resp_valid), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h28; req_wdata = 32'h12345678;
        repeat (3) begin
            @(posedge clk); #1;
            check("in_rst_valid", 32'(resp_valid), 32'd0);
        end
        req_valid = 1'b0;
        rst = 1'b1;
        do_req(1'b1, 3'd2, 32'h24, 32'hCAFEF00D, 0, rd, er);
        do_req(1'b0, 3'd2, 32'h28, 32'd0, 0, rd, er);
        do_req(1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
        check("post_abort_lw", rd, 32'hDEAD55EF);

        for (int t = 0; t < 120; t++) begin
            if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, 63));
            else if ($urandom_range(0, 1) == 0) a = 32'(4 * DEPTH + $urandom_range(0, 15));
            else a = $urandom;
            do_req(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom,
                   $urandom_range(0, 2), rd, er);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
